regfile_mp_sb: RTL and testbench

REGFILE_MP_SB -- requirements
Module: regfile_mp_sb

---
 rtl/regfile_mp_sb.sv | 111 +++++++++++
 tb/tb_regfile_mp_sb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp_sb
//  Description : Multi-read-port register file with two write ports and a
//                per-register busy (pending producer) scoreboard. Reads are
//                combinational with write-through bypass; write port 1 wins
//                over write port 0 on an address collision.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp_sb #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         wr0_en,
  input  logic [ADDR_WIDTH-1:0]        wr0_addr,
  input  logic [DATA_WIDTH-1:0]        wr0_data,
  input  logic                         wr1_en,
  input  logic [ADDR_WIDTH-1:0]        wr1_addr,
  input  logic [DATA_WIDTH-1:0]        wr1_data,
  input  logic                         iss_en,
  input  logic [ADDR_WIDTH-1:0]        iss_addr,
  input  logic                         flush
);

  localparam bit C_ZERO = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] data_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] data_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;

  // Effective enables: anything aimed at a hardwired-zero r0 is discarded
  // here, so both the commit path and the bypass path ignore it.
  logic wr0_vld;
  logic wr1_vld;
  logic iss_vld;

  assign wr0_vld = wr0_en && !(C_ZERO && (wr0_addr == '0));
  assign wr1_vld = wr1_en && !(C_ZERO && (wr1_addr == '0));
  assign iss_vld = iss_en && !(C_ZERO && (iss_addr == '0));

  // Next-state: reset beats everything; then flush, writes (wr1 last so it
  // wins a collision), and finally issue so a new producer keeps busy set.
  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end
    if (wr0_vld) begin
      data_d[wr0_addr] = wr0_data;
      busy_d[wr0_addr] = 1'b0;
    end
    if (wr1_vld) begin
      data_d[wr1_addr] = wr1_data;
      busy_d[wr1_addr] = 1'b0;
    end
    if (iss_vld) begin
      busy_d[iss_addr] = 1'b1;
    end
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data_d[i] = '0;
      end
      busy_d = '0;
    end
  end

  // State registers; synchronous reset is already folded into the _d values.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    busy_q <= busy_d;
  end

  // Independent combinational read ports with write-through bypass.
  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr_k;
      logic                  hit0;
      logic                  hit1;

      assign addr_k = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign hit0   = wr0_vld && (wr0_addr == addr_k);
      assign hit1   = wr1_vld && (wr1_addr == addr_k);

      // Zero register first, then bypass (port 1 priority), then storage.
      always_comb begin
        rd_data[k*DATA_WIDTH +: DATA_WIDTH] = data_q[addr_k];
        rd_busy[k] = busy_q[addr_k] && !(hit0 || hit1);
        if (C_ZERO && (addr_k == '0)) begin
          rd_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
          rd_busy[k] = 1'b0;
        end else if (hit1) begin
          rd_data[k*DATA_WIDTH +: DATA_WIDTH] = wr1_data;
        end else if (hit0) begin
          rd_data[k*DATA_WIDTH +: DATA_WIDTH] = wr0_data;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp_sb
//  Description : Scoreboard bench for regfile_mp_sb. Stimulus drives a cycle
//                and queues the read results expected for it; a monitor on
//                the falling edge pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp_sb;

  localparam int DW = 64;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NP = 2;

  typedef struct {
    string         name;
    int            port;
    logic [DW-1:0] data;
    logic          busy;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*DW-1:0] rd_data;
  logic [NP-1:0]   rd_busy;
  logic            wr0_en, wr1_en, iss_en, flush;
  logic [AW-1:0]   wr0_addr, wr1_addr, iss_addr;
  logic [DW-1:0]   wr0_data, wr1_data;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  regfile_mp_sb #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .NUM_RD(NP), .ZERO_REG(1)
  ) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr0_en(wr0_en), .wr0_addr(wr0_addr),
    .wr0_data(wr0_data), .wr1_en(wr1_en), .wr1_addr(wr1_addr),
    .wr1_data(wr1_data), .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
  );

  always #5 clk = ~clk;

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [DW-1:0] got_d;
      logic          got_b;
      e     = exp_q.pop_front();
      got_d = rd_data[e.port*DW +: DW];
      got_b = rd_busy[e.port];
      n_checks++;
      if (got_d !== e.data || got_b !== e.busy) begin
        n_err++;
        $display("FAIL %s port%0d: data=%h busy=%b, required data=%h busy=%b",
                 e.name, e.port, got_d, got_b, e.data, e.busy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_en = 0; wr1_en = 0; iss_en = 0; flush = 0;
    wr0_addr = '0; wr1_addr = '0; iss_addr = '0;
    wr0_data = '0; wr1_data = '0;
  endtask

  task automatic rd(input int p0, input int p1);
    rd_addr[0 +: AW]  = AW'(p0);
    rd_addr[AW +: AW] = AW'(p1);
  endtask

  task automatic exp(input string name, input int port,
                     input logic [DW-1:0] data, input logic busy);
    exp_t e;
    e.name = name; e.port = port; e.data = data; e.busy = busy;
    exp_q.push_back(e);
  endtask

  task automatic wr0(input int a, input logic [DW-1:0] d);
    wr0_en = 1; wr0_addr = AW'(a); wr0_data = d;
  endtask

  task automatic wr1(input int a, input logic [DW-1:0] d);
    wr1_en = 1; wr1_addr = AW'(a); wr1_data = d;
  endtask

  task automatic iss(input int a);
    iss_en = 1; iss_addr = AW'(a);
  endtask

  initial begin
    idle();
    rd_addr = '0;
    reset = 1;
    cyc(); cyc();
    reset = 0;

    // Post-reset sweep: every register reads zero and not busy on both ports.
    for (int a = 0; a < NR; a++) begin
      rd(a, NR - 1 - a);
      exp("reset_sweep", 0, '0, 1'b0);
      exp("reset_sweep", 1, '0, 1'b0);
      cyc();
    end

    // Same-address double write: port 1 data bypassed and stored.
    wr0(5, 64'hA5A5); wr1(5, 64'h5A5A); rd(5, 6);
    exp("wcoll_bypass", 0, 64'h5A5A, 1'b0);
    exp("wcoll_other", 1, '0, 1'b0);
    cyc(); idle();
    exp("wcoll_stored", 0, 64'h5A5A, 1'b0);
    cyc();

    // Different-address dual write, each port bypassed, then stored.
    wr0(10, 64'h10); wr1(11, 64'h11); rd(10, 11);
    exp("dual_byp0", 0, 64'h10, 1'b0);
    exp("dual_byp1", 1, 64'h11, 1'b0);
    cyc(); idle();
    exp("dual_st0", 0, 64'h10, 1'b0);
    exp("dual_st1", 1, 64'h11, 1'b0);
    cyc();

    // Issue r7, observe busy, resolve with wr0.
    iss(7); rd(7, 5);
    exp("iss7_same", 0, '0, 1'b0);
    cyc(); idle();
    exp("iss7_busy", 0, '0, 1'b1);
    cyc();
    wr0(7, 64'h1234);
    exp("iss7_wr_byp", 0, 64'h1234, 1'b0);
    cyc(); idle();
    exp("iss7_cleared", 0, 64'h1234, 1'b0);
    cyc();

    // Issue and write r9 together: new producer keeps busy.
    iss(9); wr1(9, 64'h77); rd(5, 9);
    exp("iss9_wr_byp", 1, 64'h77, 1'b0);
    cyc(); idle();
    exp("iss9_busy", 1, 64'h77, 1'b1);
    cyc();
    wr1(9, 64'h88);
    exp("r9_wr_masks", 1, 64'h88, 1'b0);
    cyc(); idle();
    exp("r9_cleared", 1, 64'h88, 1'b0);
    cyc();

    // Zero register ignores writes and issues, including bypass.
    wr0(0, 64'hFFFF); wr1(0, 64'hEEEE); iss(0); rd(0, 0);
    exp("zero_byp", 0, '0, 1'b0);
    exp("zero_byp", 1, '0, 1'b0);
    cyc(); idle();
    exp("zero_after", 0, '0, 1'b0);
    cyc();

    // Issue r3, r4, then flush together with issue r6.
    iss(3); cyc();
    iss(4); cyc();
    idle(); flush = 1; iss(6); rd(3, 4);
    exp("flush_pre3", 0, '0, 1'b1);
    exp("flush_pre4", 1, '0, 1'b1);
    cyc(); idle(); rd(3, 6);
    exp("flush_r3", 0, '0, 1'b0);
    exp("flush_r6", 1, '0, 1'b1);
    cyc(); rd(4, 5);
    exp("flush_r4", 0, '0, 1'b0);
    exp("flush_data", 1, 64'h5A5A, 1'b0);
    cyc();

    // Reset mid-sequence beats a simultaneous write and issue.
    iss(20); wr0(21, 64'hBEEF);
    cyc(); idle();
    reset = 1; wr0(22, 64'h22); iss(22); rd(22, 21);
    exp("rst_byp22", 0, 64'h22, 1'b0);
    exp("rst_old21", 1, 64'hBEEF, 1'b0);
    cyc(); idle(); reset = 0; rd(22, 21);
    exp("rst_r22", 0, '0, 1'b0);
    exp("rst_r21", 1, '0, 1'b0);
    cyc(); rd(20, 6);
    exp("rst_busy20", 0, '0, 1'b0);
    exp("rst_busy6", 1, '0, 1'b0);
    cyc(); rd(5, 9);
    exp("rst_r5", 0, '0, 1'b0);
    exp("rst_r9", 1, '0, 1'b0);
    cyc();

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) cyc();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
